// File: rtl/rx_module.sv
// rx_module: 8N1 UART receiver with 2-flop input synchronizer, mid-bit
// sampling and break detection. data holds the last correctly framed byte.
// Optional build macro RX_MAJORITY_EN: every sample point uses the 2-of-3
// majority of the synchronized line at counts N-2, N-1 and N, so a single
// clock of noise at a sample point is ignored. Decision timing is identical
// in both builds.
module rx_module #(
  parameter int CLK_HZ = 27000000,
  parameter int BAUD   = 115200
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int PERIOD = CLK_HZ / BAUD;
  localparam int HALF   = PERIOD / 2;
  localparam logic [8:0] PER_LAST  = 9'(PERIOD - 1);
  localparam logic [8:0] HALF_LAST = 9'(HALF - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        meta_q, meta_d;
  logic        rx_s_q, rx_s_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        sample;

`ifdef RX_MAJORITY_EN
  logic [1:0]  hist_q, hist_d;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Line value as seen at the current sample point (majority of last three)
  always_comb begin
    hist_d = {hist_q[0], rx_s_q};
    sample = maj3(hist_q[1], hist_q[0], rx_s_q);
  end

  // History of the synchronized line for the majority vote
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) hist_q <= 2'b11;
    else      hist_q <= hist_d;
  end
`else
  // Line value as seen at the current sample point (single sample)
  always_comb begin
    sample = rx_s_q;
  end
`endif

  // Next-state, counters, shift register and output pulses
  always_comb begin
    meta_d  = rx;
    rx_s_d  = meta_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          cnt_d   = 9'd0;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = 9'd0;
          if (!sample) begin
            state_d = DATA;
            idx_d   = 3'd0;
          end else begin
            state_d = IDLE;  // glitch shorter than half a bit
          end
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      DATA: begin
        if (cnt_q == PER_LAST) begin
          cnt_d          = 9'd0;
          shift_d[idx_q] = sample;
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      STOP: begin
        if (cnt_q == PER_LAST) begin
          cnt_d = 9'd0;
          if (sample) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;  // wait out the low line so only one error fires
          end
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      BREAK: begin
        if (rx_s_q) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      meta_q  <= 1'b1;
      rx_s_q  <= 1'b1;
      cnt_q   <= 9'd0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      meta_q  <= meta_d;
      rx_s_q  <= rx_s_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != IDLE);

endmodule
